// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Arbitrates register-file writeback among NUM_REQ execution units
//   (0 = ALU, 1 = LSU, 2 = MDU) with a round-robin pointer, registers the
//   winning write for one cycle, and keeps a busy scoreboard of destination
//   registers that have been issued but not yet written back.
//
// Ports:
//   Clk_Core            in   core clock, rising edge
//   Rst_Core_N          in   asynchronous active-low reset
//   Req_Valid[N]        in   per-requester writeback request
//   Req_Addr[5N]        in   per-requester destination (requester k at [5k+4:5k])
//   Req_Data[32N]       in   per-requester result (requester k at [32k+31:32k])
//   Req_Ready[N]        out  one-hot grant (combinational)
//   Hold                in   suppresses all grants while high
//   Iss_Valid/Iss_Addr  in   issued instruction marks its destination busy
//   Rs1_Addr/Rs2_Addr   in   source lookups
//   Rs1_Busy/Rs2_Busy   out  source has a pending write (combinational)
//   Busy_Vec[32]        out  scoreboard; bit 0 is always 0
//   Wr_En               out  registered register-file write enable
//   Write_Addr_Port_1   out  registered write address
//   Write_Data_Port_1   out  registered write data
//
// Handshake: a writeback transfers on a rising edge where Req_Valid[k] and
// Req_Ready[k] are both high. Req_Ready never depends on whether the
// requester keeps Req_Valid up afterwards; the requester must hold
// Req_Addr/Req_Data stable while Req_Valid is high and Req_Ready is low.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                    Clk_Core,
  input  logic                    Rst_Core_N,
  input  logic [NUM_REQ-1:0]      Req_Valid,
  input  logic [5*NUM_REQ-1:0]    Req_Addr,
  input  logic [32*NUM_REQ-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]      Req_Ready,
  input  logic                    Hold,
  input  logic                    Iss_Valid,
  input  logic [4:0]              Iss_Addr,
  input  logic [4:0]              Rs1_Addr,
  input  logic [4:0]              Rs2_Addr,
  output logic                    Rs1_Busy,
  output logic                    Rs2_Busy,
  output logic [31:0]             Busy_Vec,
  output logic                    Wr_En,
  output logic [4:0]              Write_Addr_Port_1,
  output logic [31:0]             Write_Data_Port_1
);

  localparam int            PW     = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [PW:0]   NREQ_W = (PW+1)'(NUM_REQ);

  // State
  logic [PW-1:0]      r_rr_ptr;
  logic [31:0]        r_busy;
  logic               r_wr_en;
  logic [4:0]         r_waddr;
  logic [31:0]        r_wdata;

  // Arbitration and next-state signals
  logic [PW:0]        w_cand;
  logic               w_found;
  logic [PW-1:0]      w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_hs;
  logic [4:0]         w_gnt_addr;
  logic [31:0]        w_gnt_data;
  logic [PW:0]        w_inc;
  logic [PW-1:0]      w_ptr_next;
  logic [31:0]        w_busy_next;

  // Round-robin search: walk candidates rr_ptr, rr_ptr+1, ... modulo
  // NUM_REQ and take the first valid one. One extra bit on w_cand lets the
  // wrap work for non-power-of-two NUM_REQ.
  always_comb begin
    w_cand    = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, r_rr_ptr} + (PW+1)'(i);
      if (w_cand >= NREQ_W) begin
        w_cand = w_cand - NREQ_W;
      end
      if (!w_found && Req_Valid[w_cand[PW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[PW-1:0];
      end
    end
  end

  // Grant is suppressed by Hold and while reset is asserted.
  always_comb begin
    w_gnt      = '0;
    w_gnt_addr = '0;
    w_gnt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_found && !Hold && Rst_Core_N && (w_gnt_idx == PW'(k))) begin
        w_gnt[k]   = 1'b1;
        w_gnt_addr = Req_Addr[5*k +: 5];
        w_gnt_data = Req_Data[32*k +: 32];
      end
    end
  end

  assign w_hs = |(w_gnt & Req_Valid);

  always_comb begin
    w_inc      = {1'b0, w_gnt_idx} + (PW+1)'(1);
    w_ptr_next = r_rr_ptr;
    if (w_hs) begin
      w_ptr_next = (w_inc == NREQ_W) ? '0 : w_inc[PW-1:0];
    end
  end

  // Scoreboard: the clear for the write leaving the pipe is applied first so
  // that a same-edge re-issue of that register leaves it busy.
  always_comb begin
    w_busy_next = r_busy;
    if (r_wr_en) begin
      w_busy_next[r_waddr] = 1'b0;
    end
    if (Iss_Valid && (Iss_Addr != 5'd0)) begin
      w_busy_next[Iss_Addr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      r_rr_ptr <= '0;
      r_busy   <= '0;
      r_wr_en  <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_rr_ptr <= w_ptr_next;
      r_busy   <= w_busy_next;
      // A write to x0 still completes the handshake but never reaches the
      // register file.
      r_wr_en  <= w_hs && (w_gnt_addr != 5'd0);
      if (w_hs) begin
        r_waddr <= w_gnt_addr;
        r_wdata <= w_gnt_data;
      end
    end
  end

  assign Req_Ready         = w_gnt;
  assign Busy_Vec          = r_busy;
  assign Rs1_Busy          = r_busy[Rs1_Addr];
  assign Rs2_Busy          = r_busy[Rs2_Addr];
  assign Wr_En             = r_wr_en;
  assign Write_Addr_Port_1 = r_waddr;
  assign Write_Data_Port_1 = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed scenarios followed by a randomized run, all checked cycle by cycle
// against a behavioural model (pointer as an int, scoreboard as a 32-bit
// vector, pending writes in an expected queue).
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int N = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT signals
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_addr;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            hold;
  logic            iss_valid;
  logic [4:0]      iss_addr;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [31:0]     busy_vec;
  logic            wr_en;
  logic [4:0]      waddr;
  logic [31:0]     wdata;

  regfile_wb_arbiter #(.NUM_REQ(N)) dut (
    .Clk_Core          (clk),
    .Rst_Core_N        (rst_n),
    .Req_Valid         (req_valid),
    .Req_Addr          (req_addr),
    .Req_Data          (req_data),
    .Req_Ready         (req_ready),
    .Hold              (hold),
    .Iss_Valid         (iss_valid),
    .Iss_Addr          (iss_addr),
    .Rs1_Addr          (rs1_addr),
    .Rs2_Addr          (rs2_addr),
    .Rs1_Busy          (rs1_busy),
    .Rs2_Busy          (rs2_busy),
    .Busy_Vec          (busy_vec),
    .Wr_En             (wr_en),
    .Write_Addr_Port_1 (waddr),
    .Write_Data_Port_1 (wdata)
  );

  // Counters
  int n_checks = 0;
  int n_errs   = 0;

  // Reference model
  int          m_ptr;
  logic [31:0] m_busy;
  logic [36:0] exp_q[$];
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [N-1:0] exp_rdy;
  int          exp_k;

  // Values observed in the most recent step
  logic [N-1:0] obs_rdy;
  logic         obs_wr;
  logic         obs_rs1;
  logic [4:0]   obs_waddr;
  logic [31:0]  obs_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_busy  = '0;
    exp_q.delete();
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic set_req(input int k, input logic [4:0] a, input logic [31:0] d);
    req_addr[5*k +: 5]   = a;
    req_data[32*k +: 32] = d;
  endtask

  // One clock cycle: called at a falling edge with inputs already driven.
  task automatic step(input string tag);
    logic [36:0] w;
    logic        e_wr;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    logic [4:0]  g_a;
    #1;
    exp_rdy = '0;
    exp_k   = -1;
    if (!hold) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (exp_k < 0 && req_valid[k]) exp_k = k;
      end
    end
    if (exp_k >= 0) exp_rdy[exp_k] = 1'b1;
    e_wr = 1'b0;
    e_a  = m_waddr;
    e_d  = m_wdata;
    if (exp_q.size() > 0) begin
      w    = exp_q.pop_front();
      e_wr = 1'b1;
      e_a  = w[36:32];
      e_d  = w[31:0];
    end
    check({tag, "/ready"}, req_ready, exp_rdy);
    check({tag, "/wr_en"}, wr_en, e_wr);
    check({tag, "/waddr"}, waddr, e_a);
    check({tag, "/wdata"}, wdata, e_d);
    check({tag, "/busy_vec"}, busy_vec, m_busy);
    check({tag, "/rs1_busy"}, rs1_busy, m_busy[rs1_addr]);
    check({tag, "/rs2_busy"}, rs2_busy, m_busy[rs2_addr]);
    obs_rdy   = req_ready;
    obs_wr    = wr_en;
    obs_rs1   = rs1_busy;
    obs_waddr = waddr;
    obs_wdata = wdata;
    @(posedge clk);
    if (e_wr) m_busy[e_a] = 1'b0;
    if (iss_valid && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
    if (exp_k >= 0) begin
      g_a     = req_addr[5*exp_k +: 5];
      m_waddr = g_a;
      m_wdata = req_data[32*exp_k +: 32];
      if (g_a != 5'd0) exp_q.push_back({g_a, m_wdata});
      m_ptr = (exp_k + 1) % N;
    end
    @(negedge clk);
  endtask

  logic [N-1:0] rr_seq [6];

  initial begin
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    hold      = 1'b0;
    iss_valid = 1'b0;
    iss_addr  = '0;
    rs1_addr  = 5'd7;
    rs2_addr  = 5'd0;
    model_reset();

    // Reset state
    #2;
    check("reset/ready", req_ready, 3'b000);
    check("reset/wr_en", wr_en, 1'b0);
    check("reset/waddr", waddr, 5'd0);
    check("reset/wdata", wdata, 32'd0);
    check("reset/busy_vec", busy_vec, 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin with all three requesting
    set_req(0, 5'd1, 32'hA0A0_0001);
    set_req(1, 5'd2, 32'hB0B0_0002);
    set_req(2, 5'd3, 32'hC0C0_0003);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step("rr");
      check("rr/seq", obs_rdy, rr_seq[i]);
      check("rr/wr_seq", obs_wr, (i > 0));
    end
    req_valid = '0;
    step("rr_tail");
    check("rr/wr_last", obs_wr, 1'b1);

    // Single request, 1-cycle latency
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    step("single");
    check("single/ready", obs_rdy, 3'b001);
    req_valid = '0;
    step("single_wr");
    check("single/wr_en", obs_wr, 1'b1);
    check("single/waddr", obs_waddr, 5'd5);
    check("single/wdata", obs_wdata, 32'hDEAD_BEEF);
    step("single_idle");
    check("single/wr_off", obs_wr, 1'b0);

    // Issue and write to x0
    iss_valid = 1'b1;
    iss_addr  = 5'd0;
    set_req(2, 5'd0, 32'h1234_5678);
    req_valid = 3'b100;
    step("x0");
    check("x0/ready", obs_rdy, 3'b100);
    iss_valid = 1'b0;
    req_valid = '0;
    step("x0_next");
    check("x0/wr_en", obs_wr, 1'b0);
    check("x0/busy_vec", busy_vec, 32'd0);

    // Hold: pointer must stay at 1 across the held cycles
    set_req(0, 5'd9, 32'h0000_0009);
    req_valid = 3'b001;
    step("hold_pre");
    req_valid = '0;
    step("hold_gap");
    set_req(1, 5'd10, 32'h0000_000A);
    hold      = 1'b1;
    req_valid = 3'b011;
    for (int i = 0; i < 3; i++) begin
      step("hold");
      check("hold/ready", obs_rdy, 3'b000);
      check("hold/wr_en", obs_wr, 1'b0);
    end
    hold = 1'b0;
    step("hold_rel");
    check("hold/release_grant", obs_rdy, 3'b010);
    req_valid = '0;
    step("hold_tail");

    // Scoreboard: issue 7, LSU writes 7 two cycles later
    rs1_addr  = 5'd7;
    iss_valid = 1'b1;
    iss_addr  = 5'd7;
    step("sb_iss");
    iss_valid = 1'b0;
    step("sb_wait");
    check("sb/rs1_after_issue", obs_rs1, 1'b1);
    set_req(1, 5'd7, 32'h7777_0007);
    req_valid = 3'b010;
    step("sb_req");
    check("sb/lsu_grant", obs_rdy, 3'b010);
    check("sb/rs1_pending", obs_rs1, 1'b1);
    req_valid = '0;
    step("sb_wr");
    check("sb/wr_en", obs_wr, 1'b1);
    check("sb/rs1_on_wr", obs_rs1, 1'b1);
    step("sb_after");
    check("sb/rs1_cleared", obs_rs1, 1'b0);
    // Same again, re-issuing 7 on the write edge
    iss_valid = 1'b1;
    step("sb2_iss");
    iss_valid = 1'b0;
    step("sb2_wait");
    req_valid = 3'b010;
    step("sb2_req");
    req_valid = '0;
    iss_valid = 1'b1;
    iss_addr  = 5'd7;
    step("sb2_wr");
    check("sb2/wr_en", obs_wr, 1'b1);
    iss_valid = 1'b0;
    step("sb2_after");
    check("sb2/rs1_kept", obs_rs1, 1'b1);

    // Reset right after a handshake
    iss_valid = 1'b1;
    iss_addr  = 5'd4;
    step("rst_iss");
    iss_valid = 1'b0;
    check("rst/busy_pre", busy_vec, 32'h0000_0090);
    set_req(0, 5'd11, 32'h0000_000B);
    req_valid = 3'b001;
    step("rst_hs");
    req_valid = 3'b111;
    #1 rst_n = 1'b0;
    #1;
    check("rst/ready", req_ready, 3'b000);
    check("rst/wr_en", wr_en, 1'b0);
    check("rst/waddr", waddr, 5'd0);
    check("rst/wdata", wdata, 32'd0);
    check("rst/busy_vec", busy_vec, 32'd0);
    check("rst/rs1_busy", rs1_busy, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
    step("rst_post");
    check("rst/first_grant", obs_rdy, 3'b001);
    check("rst/no_stale_wr", obs_wr, 1'b0);
    req_valid = '0;
    step("rst_tail");

    // Randomized traffic
    exp_rdy = '0;
    for (int c = 0; c < 400; c++) begin
      hold      = ($urandom_range(0, 7) == 0);
      iss_valid = $urandom_range(0, 1);
      iss_addr  = 5'($urandom_range(0, 15));
      rs1_addr  = 5'($urandom_range(0, 15));
      rs2_addr  = 5'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] || exp_rdy[k]) begin
          req_valid[k] = ($urandom_range(0, 2) != 0);
          set_req(k, 5'($urandom_range(0, 15)), $urandom);
        end
      end
      step("rand");
    end
    req_valid = '0;
    hold      = 1'b0;
    iss_valid = 1'b0;
    step("rand_drain");
    step("rand_idle");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
